instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory port. Owns the PC and issues word-address

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to a 1-cycle instruction
// memory, buffers returned words in a small FIFO and hands them to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_add,
  output logic        mem_enable,
  input  logic [31:0] mem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW         = AW + 1;
  localparam logic [CW:0] DEPTH_W    = (CW + 1)'(DEPTH);
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  logic [31:0]   pc_reg, pc_next;
  logic          pend_reg, pend_next;
  logic [31:0]   pend_pc_reg, pend_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;

  logic [31:0]   instr_store [DEPTH];
  logic [31:0]   pc_store    [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic [CW:0]   credit_used;

  // Buffered words plus the one in flight must never exceed the FIFO size,
  // so a returning word always has a free slot.
  always_comb begin
    credit_used = {1'b0, count_reg} + {{CW{1'b0}}, pend_reg};
    issue       = ~reset & ~redirect_valid & (credit_used < DEPTH_W);
    push        = pend_reg & ~redirect_valid;
    not_empty   = (count_reg != '0);
    pop         = not_empty & ~redirect_valid & out_ready;
  end

  assign mem_enable = issue;
  assign mem_add    = {2'b00, pc_reg[31:2]};
  assign out_valid  = not_empty & ~redirect_valid;
  assign out_instr  = not_empty ? instr_store[rd_ptr_reg] : '0;
  assign out_pc     = not_empty ? pc_store[rd_ptr_reg]    : '0;

  always_comb begin
    pc_next      = pc_reg;
    pend_next    = issue;
    pend_pc_next = pend_pc_reg;
    count_next   = count_reg;
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    if (redirect_valid) begin
      // Drop everything buffered or in flight and restart at the new target.
      pc_next     = {redirect_pc[31:2], 2'b00};
      pend_next   = 1'b0;
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (issue) begin
        pc_next      = pc_reg + 32'd4;
        pend_pc_next = pc_reg;
      end
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg      <= RESET_PC_W;
      pend_reg    <= 1'b0;
      pend_pc_reg <= '0;
      count_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
    end else begin
      pc_reg      <= pc_next;
      pend_reg    <= pend_next;
      pend_pc_reg <= pend_pc_next;
      count_reg   <= count_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
    end
  end

  // Storage is only ever written with a returned word; reads are masked while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_store[wr_ptr_reg] <= mem_instr;
      pc_store[wr_ptr_reg]    <= pend_pc_reg;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences for
// backpressure/reset/wrap, and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_add;
  logic        mem_enable;
  logic [31:0] mem_instr = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_reset;
  logic [31:0] w_mem_add;
  logic        w_mem_enable;
  logic [31:0] w_mem_instr = '0;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .mem_add(mem_add), .mem_enable(mem_enable),
    .mem_instr(mem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clock(clock), .reset(w_reset), .mem_add(w_mem_add), .mem_enable(w_mem_enable),
    .mem_instr(w_mem_instr), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc)
  );

  // Instruction memory: 1-cycle registered ROM, rom[i] = A000_0000 + i.
  always @(posedge clock) if (mem_enable) mem_instr <= 32'hA000_0000 + mem_add;
  always @(posedge clock) if (w_mem_enable) w_mem_instr <= 32'hA000_0000 + w_mem_add;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        me;
    logic [31:0] add;
    logic        ov;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [16];

  typedef struct {
    logic [31:0] pc;
    int unsigned due;
  } fetch_t;

  fetch_t      q [$];
  logic [31:0] exp_pc;
  int unsigned cyc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int got;
    int cycles;
    int bias;
    int delivered;
    logic exp_me;
    logic exp_ov;

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    w_reset = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_out_ready = 1'b1;

    // Reset release with out_ready=1, redirect to 0x43, then redirect to 0x40
    // while two words are buffered and one is in flight.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h01, 1'b0, 32'h0,         32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h02, 1'b1, 32'hA000_0000, 32'h00};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h03, 1'b1, 32'hA000_0001, 32'h04};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 1'b1, 32'hA000_0002, 32'h08};
    tbl[5]  = '{1'b1, 1'b1, 32'h43, 1'b0, 32'h00, 1'b0, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h0,         32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h11, 1'b0, 32'h0,         32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h12, 1'b1, 32'hA000_0010, 32'h40};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h13, 1'b1, 32'hA000_0011, 32'h44};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 32'hA000_0012, 32'h48};
    tbl[11] = '{1'b0, 1'b1, 32'h40, 1'b0, 32'h00, 1'b0, 32'h0,         32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h0,         32'h0};
    tbl[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h11, 1'b0, 32'h0,         32'h0};
    tbl[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h12, 1'b1, 32'hA000_0010, 32'h40};
    tbl[15] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h13, 1'b1, 32'hA000_0011, 32'h44};

    #2;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_mem_enable", {31'b0, mem_enable}, 32'd0);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("vec%0d_mem_enable", i), {31'b0, mem_enable}, {31'b0, tbl[i].me});
      if (tbl[i].me) chk($sformatf("vec%0d_mem_add", i), mem_add, tbl[i].add);
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d_out_instr", i), out_instr, tbl[i].instr);
        chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].pc);
      end
      $display("vec %0d: rdy=%0b redir=%0b me=%0b add=%h ov=%0b instr=%h pc=%h",
               i, out_ready, redirect_valid, mem_enable, mem_add, out_valid, out_instr, out_pc);
      @(negedge clock);
    end
    redirect_valid = 1'b0;

    // Backpressure from reset: exactly DEPTH requests, head held, then drain.
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      pulses += int'(mem_enable);
      if (c >= 2) begin
        chk($sformatf("bp_hold_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
        chk($sformatf("bp_hold_instr_c%0d", c), out_instr, 32'hA000_0000);
      end
      @(negedge clock);
    end
    chk("bp_issue_pulses", pulses, DEPTH);
    #1;
    chk("bp_issue_stopped", {31'b0, mem_enable}, 32'd0);
    out_ready = 1'b1;
    got = 0; cycles = 0;
    while (got < 5 && cycles < 20) begin
      if (out_valid) begin
        chk($sformatf("bp_drain_pc%0d", got), out_pc, 32'(got * 4));
        chk($sformatf("bp_drain_instr%0d", got), out_instr, 32'hA000_0000 + 32'(got));
        $display("drain word %0d: instr=%h pc=%h", got, out_instr, out_pc);
        got++;
      end
      cycles++;
      @(negedge clock);
      #1;
    end
    chk("bp_drain_words", got, 5);
    chk("bp_drain_cycles", cycles, 5);

    // Reset mid-stream with three buffered words.
    @(negedge clock);
    out_ready = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    chk("mid_pre_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_async_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_async_enable", {31'b0, mem_enable}, 32'd0);
    chk("mid_async_instr", out_instr, 32'd0);
    chk("mid_async_pc", out_pc, 32'd0);
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_restart_enable", {31'b0, mem_enable}, 32'd1);
    chk("mid_restart_add", mem_add, 32'h0);
    chk("mid_restart_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clock); #1;
    chk("mid_restart_add1", mem_add, 32'h1);
    @(negedge clock); #1;
    chk("mid_first_valid", {31'b0, out_valid}, 32'd1);
    chk("mid_first_instr", out_instr, 32'hA000_0000);
    chk("mid_first_pc", out_pc, 32'h0);
    $display("restart word: instr=%h pc=%h", out_instr, out_pc);

    // PC wrap from the top of the address space.
    @(negedge clock);
    w_reset = 1'b0;
    #1;
    chk("wrap_enable", {31'b0, w_mem_enable}, 32'd1);
    chk("wrap_add0", w_mem_add, 32'h3FFF_FFFF);
    @(negedge clock); #1;
    chk("wrap_add1", w_mem_add, 32'h0);
    @(negedge clock); #1;
    chk("wrap_valid0", {31'b0, w_out_valid}, 32'd1);
    chk("wrap_pc0", w_out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr0", w_out_instr, 32'hDFFF_FFFF);
    @(negedge clock); #1;
    chk("wrap_pc1", w_out_pc, 32'h0);
    chk("wrap_instr1", w_out_instr, 32'hA000_0000);
    $display("wrap words: pc=%h instr=%h", w_out_pc, w_out_instr);

    // Randomized run against a queue model: every issued word is owed to decode
    // two cycles later, in issue order, unless a redirect discards it.
    @(negedge clock);
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    exp_pc = 32'h0;
    cyc = 0;
    bias = 50;
    delivered = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) bias = (n / 100) % 4 == 0 ? 10 : (n / 100) % 4 == 1 ? 50 :
                               (n / 100) % 4 == 2 ? 90 : 100;
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc = $urandom;
      out_ready = ($urandom_range(99) < bias);
      #1;
      exp_me = !redirect_valid && (q.size() < DEPTH);
      exp_ov = !redirect_valid && (q.size() > 0) && (q[0].due <= cyc);
      chk($sformatf("rnd%0d_mem_enable", n), {31'b0, mem_enable}, {31'b0, exp_me});
      if (exp_me) chk($sformatf("rnd%0d_mem_add", n), mem_add, exp_pc >> 2);
      chk($sformatf("rnd%0d_out_valid", n), {31'b0, out_valid}, {31'b0, exp_ov});
      if (exp_ov) begin
        chk($sformatf("rnd%0d_out_pc", n), out_pc, q[0].pc);
        chk($sformatf("rnd%0d_out_instr", n), out_instr, 32'hA000_0000 + (q[0].pc >> 2));
      end
      if (redirect_valid) begin
        q.delete();
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (exp_ov && out_ready) begin
          void'(q.pop_front());
          delivered++;
        end
        if (exp_me) begin
          q.push_back('{exp_pc, cyc + 2});
          exp_pc = exp_pc + 32'd4;
        end
      end
      cyc++;
      @(negedge clock);
    end
    $display("random run: %0d cycles, %0d words delivered", cyc, delivered);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
